detector_jogada: RTL and testbench

//  Player-input front end for the memory-game datapath: synchronises and debounces the 4 raw buttons.

---
 rtl/jogo_pkg.sv | 16 +
 rtl/detector_jogada_if.sv | 21 ++
 rtl/detector_jogada_sincronizador.sv | 31 +++
 rtl/detector_jogada.sv | 150 +++++++++++++++
 tb/tb_detector_jogada.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the player-input front end: FSM state encoding and parameter defaults.
package jogo_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        FILTRA      = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTA       = 2'd3
    } estado_t;

    localparam int N_BOTOES_DEF        = 4;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50_000;
    localparam int TIMEOUT_CYCLES_DEF  = 250_000_000;

endpackage

// File: rtl/detector_jogada_if.sv
// Button/status bundle between the controller side (master) and the play detector (slave).
interface detector_jogada_if #(
    parameter int N_BOTOES = jogo_pkg::N_BOTOES_DEF
);
    logic [N_BOTOES-1:0] botoes;
    logic                habilita;
    logic                jogada;
    logic [N_BOTOES-1:0] jogada_codigo;
    logic                timeout;
    logic [1:0]          db_estado;

    modport master (
        output botoes, habilita,
        input  jogada, jogada_codigo, timeout, db_estado
    );

    modport slave (
        input  botoes, habilita,
        output jogada, jogada_codigo, timeout, db_estado
    );
endinterface

// File: rtl/detector_jogada_sincronizador.sv
// Per-bit flip-flop chain bringing asynchronous inputs into the clock domain.
// Latency STAGES cycles; no backpressure (free-running).
// Reset clears every stage to 0.
module sincronizador #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_dado,
    output logic [WIDTH-1:0] o_dado
);

    logic [WIDTH-1:0] r_cadeia [STAGES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_cadeia[i] <= '0;
            end
        end else begin
            r_cadeia[0] <= i_dado;
            for (int i = 1; i < STAGES; i++) begin
                r_cadeia[i] <= r_cadeia[i-1];
            end
        end
    end

    assign o_dado = r_cadeia[STAGES-1];

endmodule

// File: rtl/detector_jogada.sv
// Debounces the buttons, emits a one-cycle jogada pulse with the one-hot code, and runs the play timeout.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES from press to pulse (from release when JOGADA_NA_SOLTURA_EN is defined).
// No backpressure: the pulse is fire-and-forget; a play is counted only while habilita is high.
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input logic               clock,
    input logic               reset,
    detector_jogada_if.slave  bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TM_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_MAX = TM_W'(TIMEOUT_CYCLES - 1);

    logic [N_BOTOES-1:0] w_padrao;
    estado_t             r_estado, w_estado_prox;
    logic [DB_W-1:0]     r_cnt, w_cnt_prox;
    logic [N_BOTOES-1:0] r_cand, w_cand_prox;
    logic                w_aceita, w_solta_fim, w_pulso;
    logic                r_jogada;
    logic [N_BOTOES-1:0] r_codigo;
    logic [TM_W-1:0]     r_timer;
    logic                r_timeout;

    sincronizador #(
        .WIDTH  (N_BOTOES),
        .STAGES (SYNC_STAGES)
    ) u_sinc (
        .clock  (clock),
        .reset  (reset),
        .i_dado (bus.botoes),
        .o_dado (w_padrao)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
            r_cand   <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_cnt    <= w_cnt_prox;
            r_cand   <= w_cand_prox;
        end
    end

    // One counter serves both the press filter and the release filter.
    always_comb begin
        w_estado_prox = r_estado;
        w_cnt_prox    = r_cnt;
        w_cand_prox   = r_cand;
        w_aceita      = 1'b0;
        w_solta_fim   = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_padrao != '0) begin
                    w_estado_prox = FILTRA;
                    w_cnt_prox    = '0;
                    w_cand_prox   = w_padrao;
                end
            end
            FILTRA: begin
                if (w_padrao == '0) begin
                    w_estado_prox = OCIOSO;
                    w_cnt_prox    = '0;
                end else if (w_padrao != r_cand) begin
                    w_cand_prox = w_padrao;
                    w_cnt_prox  = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_estado_prox = PRESSIONADO;
                    w_cnt_prox    = '0;
                    w_aceita      = 1'b1;
                end else begin
                    w_cnt_prox = r_cnt + 1'b1;
                end
            end
            PRESSIONADO: begin
                if (w_padrao == '0) begin
                    w_estado_prox = SOLTA;
                    w_cnt_prox    = '0;
                end
            end
            SOLTA: begin
                if (w_padrao != '0) begin
                    w_estado_prox = PRESSIONADO;
                    w_cnt_prox    = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_estado_prox = OCIOSO;
                    w_cnt_prox    = '0;
                    w_solta_fim   = 1'b1;
                end else begin
                    w_cnt_prox = r_cnt + 1'b1;
                end
            end
            default: begin
                w_estado_prox = OCIOSO;
                w_cnt_prox    = '0;
            end
        endcase
    end

    // r_cand is frozen after the press is accepted, so the release edge reuses it as the play code.
`ifdef JOGADA_NA_SOLTURA_EN
    assign w_pulso = w_solta_fim && bus.habilita && $onehot(r_cand) && !r_timeout;
`else
    assign w_pulso = w_aceita && bus.habilita && $onehot(r_cand) && !r_timeout;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_jogada <= 1'b0;
            r_codigo <= '0;
        end else begin
            r_jogada <= w_pulso;
            if (w_pulso) begin
                r_codigo <= r_cand;
            end
        end
    end

    // A play restarts the timer, which also resolves a pulse landing on the timeout threshold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else if (!bus.habilita || w_pulso) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_timer != TM_MAX) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.jogada        = r_jogada;
    assign bus.jogada_codigo = r_codigo;
    assign bus.timeout       = r_timeout;
    assign bus.db_estado     = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed play scenarios plus random button traffic against a run-length reference model.
module tb_detector_jogada;

    localparam int DEB = 4;
    localparam int TMO = 20;

    logic clock;
    logic reset;

    detector_jogada_if #(.N_BOTOES(4)) bus ();

    detector_jogada #(
        .N_BOTOES        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: buttons seen two edges late; a press counts once the same nonzero pattern has
    // been seen on DEB+1 consecutive edges, and re-arms after DEB+1 consecutive zero edges.
    logic [3:0] h1, h2, run_pat, press_code, m_codigo;
    int         run, hab_cnt;
    bit         armed, m_jogada, m_timeout;

    function automatic void model_reset();
        h1 = '0; h2 = '0; run_pat = '0; run = 0;
        press_code = '0; m_codigo = '0; hab_cnt = 0;
        armed = 1'b1; m_jogada = 1'b0; m_timeout = 1'b0;
    endfunction

    function automatic void model_step();
        logic [3:0] vis;
        bit         pulse;
        bit         bloqueado;
        vis = h2;
        h2  = h1;
        h1  = bus.botoes;
        if (vis == run_pat) run++;
        else begin
            run_pat = vis;
            run     = 1;
        end
        pulse     = 1'b0;
        bloqueado = (hab_cnt >= TMO);
        if (armed && vis != 4'd0 && run == DEB + 1) begin
            armed      = 1'b0;
            press_code = vis;
`ifndef JOGADA_NA_SOLTURA_EN
            pulse = bus.habilita && ($countones(vis) == 1) && !bloqueado;
`endif
        end else if (!armed && vis == 4'd0 && run == DEB + 1) begin
            armed = 1'b1;
`ifdef JOGADA_NA_SOLTURA_EN
            pulse = bus.habilita && ($countones(press_code) == 1) && !bloqueado;
`endif
        end
        if (!bus.habilita || pulse) hab_cnt = 0;
        else if (hab_cnt < TMO) hab_cnt++;
        m_jogada = pulse;
        if (pulse) m_codigo = press_code;
        m_timeout = (hab_cnt >= TMO);
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset) model_step();
        #1;
        check("jogada",  32'(bus.jogada),        32'(m_jogada));
        check("codigo",  32'(bus.jogada_codigo), 32'(m_codigo));
        check("timeout", 32'(bus.timeout),       32'(m_timeout));
    endtask

    task automatic idle(input int n);
        bus.botoes   = 4'd0;
        bus.habilita = 1'b0;
        repeat (n) tick();
    endtask

    // Holds a pattern for n edges; returns pulse count and index of the first pulse (-1 if none).
    task automatic hold(input logic [3:0] pat, input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        bus.botoes = pat;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.jogada) begin
                if (first < 0) first = i;
                pulses++;
            end
        end
    endtask

    int         np, fi, tot;
    logic [3:0] pat, onehot_base;

    initial begin
        model_reset();
        reset        = 1'b0;
        bus.botoes   = 4'd0;
        bus.habilita = 1'b0;
        #12;
        check("rst_jogada",  32'(bus.jogada),        32'd0);
        check("rst_codigo",  32'(bus.jogada_codigo), 32'd0);
        check("rst_timeout", 32'(bus.timeout),       32'd0);
        check("rst_estado",  32'(bus.db_estado),     32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(8);

        // 1: clean one-hot press
        bus.habilita = 1'b1;
        hold(4'b0100, 10, np, fi);
        check("t1_pulses", 32'(np), 32'd1);
        check("t1_index",  32'(fi), 32'd6);
        check("t1_codigo", 32'(bus.jogada_codigo), 32'h4);
        idle(8);

        // 2: bouncing press then steady
        bus.habilita = 1'b1;
        tot = 0;
        for (int k = 0; k < 3; k++) begin
            hold(4'b0100, 2, np, fi); tot += np;
            hold(4'b0000, 2, np, fi); tot += np;
        end
        hold(4'b0100, 10, np, fi); tot += np;
        check("t2_pulses", 32'(tot), 32'd1);
        check("t2_index",  32'(fi), 32'd6);
        idle(8);

        // 3: multi-button press ignored, then a valid one
        bus.habilita = 1'b1;
        hold(4'b0110, 10, np, fi);
        check("t3_multi_pulses", 32'(np), 32'd0);
        check("t3_multi_codigo", 32'(bus.jogada_codigo), 32'h4);
        idle(8);
        bus.habilita = 1'b1;
        hold(4'b0001, 10, np, fi);
        check("t3_pulses", 32'(np), 32'd1);
        check("t3_codigo", 32'(bus.jogada_codigo), 32'h1);
        idle(8);

        // 4: timeout, no play afterwards, clear on habilita drop
        bus.habilita = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 18) check("t4_before", 32'(bus.timeout), 32'd0);
            if (i == 19) check("t4_rise",   32'(bus.timeout), 32'd1);
        end
        hold(4'b0001, 10, np, fi);
        check("t4_blocked", 32'(np), 32'd0);
        check("t4_held",    32'(bus.timeout), 32'd1);
        bus.botoes   = 4'd0;
        bus.habilita = 1'b0;
        tick();
        check("t4_clear", 32'(bus.timeout), 32'd0);
        idle(8);

        // 5: button held as habilita rises never counts
        hold(4'b0010, 8, np, fi);
        bus.habilita = 1'b1;
        hold(4'b0010, 5, np, fi);
        check("t5_held_pulses", 32'(np), 32'd0);
        hold(4'b0000, 8, np, fi);
        hold(4'b0010, 8, np, fi);
        check("t5_pulses", 32'(np), 32'd1);
        idle(8);

        // 6: asynchronous reset in the middle of filtering
        bus.habilita = 1'b1;
        hold(4'b0100, 4, np, fi);
        #2;
        reset = 1'b0;
        #1;
        check("t6_jogada",  32'(bus.jogada),        32'd0);
        check("t6_codigo",  32'(bus.jogada_codigo), 32'd0);
        check("t6_timeout", 32'(bus.timeout),       32'd0);
        check("t6_estado",  32'(bus.db_estado),     32'd0);
        bus.botoes = 4'd0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        hold(4'b0000, 15, np, fi);
        check("t6_no_late", 32'(np), 32'd0);
        idle(8);

        // Press 1000 for 8 cycles then release
        bus.habilita = 1'b1;
        hold(4'b1000, 8, np, fi);
        tot = np;
        hold(4'b0000, 10, np, fi);
        tot += np;
        check("t7_pulses", 32'(tot), 32'd1);
        check("t7_codigo", 32'(bus.jogada_codigo), 32'h8);
`ifdef JOGADA_NA_SOLTURA_EN
        check("t7_release_index", 32'(fi), 32'd6);
`endif
        idle(8);

        // Random traffic
        onehot_base = 4'b0001;
        for (int s = 0; s < 300; s++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)      pat = 4'd0;
            else if (r < 75) pat = onehot_base << $urandom_range(0, 3);
            else             pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) bus.habilita = ~bus.habilita;
            hold(pat, $urandom_range(1, 9), np, fi);
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
